// File: rtl/lsu_controller.sv
// Load/store sequencer: validates a core memory access, runs the
// request/grant/response handshake on the data bus, and returns
// extended load data or a fault status with a one-cycle done pulse.
module lsu_controller #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  rwmm,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FAULT} state_t;

   localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

   state_t      r_state, w_state_nxt;
   logic        r_is_store, w_is_store;
   logic [2:0]  r_mode, w_mode;
   logic [1:0]  r_alo, w_alo;
   logic [15:0] r_cnt, w_cnt;
   logic        r_done, w_done;
   logic        r_mis, w_mis;
   logic        r_berr, w_berr;
   logic [31:0] r_rdata, w_rdata;
   logic        r_mem_req, w_mem_req;
   logic        r_mem_we, w_mem_we;
   logic [31:0] r_mem_addr, w_mem_addr;
   logic [3:0]  r_mem_be, w_mem_be;
   logic [31:0] r_mem_wdata, w_mem_wdata;

   logic        w_illegal, w_misal, w_timeout;
   logic [3:0]  w_be;
   logic [31:0] w_wd, w_shift, w_ext;

   // Request decode from the live inputs: legality, lanes and replicated data.
   always_comb begin
      if (is_store) w_illegal = (rwmm > 3'b010);
      else          w_illegal = (rwmm == 3'b011) || (rwmm == 3'b110) || (rwmm == 3'b111);
      w_misal = ((rwmm[1:0] == 2'b01) && addr[0]) ||
                ((rwmm[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      case (rwmm[1:0])
         2'b00:   begin w_be = 4'b0001 << addr[1:0]; w_wd = {4{wdata[7:0]}};  end
         2'b01:   begin w_be = 4'b0011 << addr[1:0]; w_wd = {2{wdata[15:0]}}; end
         default: begin w_be = 4'b1111;              w_wd = wdata;            end
      endcase
   end

   // Load data alignment and sign/zero extension based on the latched mode.
   always_comb begin
      w_shift = mem_rdata >> {r_alo, 3'b000};
      case (r_mode)
         3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b100:  w_ext = {24'h0, w_shift[7:0]};
         3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b101:  w_ext = {16'h0, w_shift[15:0]};
         default: w_ext = w_shift;
      endcase
   end

   // Next-state and next-output logic; all outputs are registered.
   always_comb begin
      w_state_nxt = r_state;
      w_is_store  = r_is_store;
      w_mode      = r_mode;
      w_alo       = r_alo;
      w_cnt       = r_cnt;
      w_done      = 1'b0;
      w_mis       = 1'b0;
      w_berr      = 1'b0;
      w_rdata     = r_rdata;
      w_mem_req   = r_mem_req;
      w_mem_we    = r_mem_we;
      w_mem_addr  = r_mem_addr;
      w_mem_be    = r_mem_be;
      w_mem_wdata = r_mem_wdata;
      // >= rather than == so a grant on the last budgeted cycle leaves WAIT no slack
      w_timeout   = (r_cnt >= LIMIT);
      case (r_state)
         S_IDLE: begin
            w_cnt = '0;
            if (start) begin
               w_is_store = is_store;
               w_mode     = rwmm;
               w_alo      = addr[1:0];
               if (w_illegal || w_misal) begin
                  w_state_nxt = S_FAULT;
                  w_done      = 1'b1;
                  w_mis       = 1'b1;
               end else begin
                  w_state_nxt = S_REQ;
                  w_mem_req   = 1'b1;
                  w_mem_we    = is_store;
                  w_mem_addr  = {addr[31:2], 2'b00};
                  w_mem_be    = w_be;
                  w_mem_wdata = w_wd;
               end
            end
         end
         S_REQ: begin
            w_cnt = r_cnt + 16'd1;
            if (mem_gnt) begin
               w_mem_req = 1'b0;
               w_mem_we  = 1'b0;
               if (r_is_store) begin
                  w_done      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else if (w_timeout) begin
               w_mem_req   = 1'b0;
               w_mem_we    = 1'b0;
               w_done      = 1'b1;
               w_berr      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            w_cnt = r_cnt + 16'd1;
            if (mem_rvalid) begin
               w_rdata     = w_ext;
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_timeout) begin
               w_done      = 1'b1;
               w_berr      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_is_store  <= 1'b0;
         r_mode      <= '0;
         r_alo       <= '0;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_mis       <= 1'b0;
         r_berr      <= 1'b0;
         r_rdata     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_is_store  <= w_is_store;
         r_mode      <= w_mode;
         r_alo       <= w_alo;
         r_cnt       <= w_cnt;
         r_done      <= w_done;
         r_mis       <= w_mis;
         r_berr      <= w_berr;
         r_rdata     <= w_rdata;
         r_mem_req   <= w_mem_req;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_be    <= w_mem_be;
         r_mem_wdata <= w_mem_wdata;
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign done       = r_done;
   assign misaligned = r_mis;
   assign bus_err    = r_berr;
   assign rdata      = r_rdata;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_be     = r_mem_be;
   assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: table of single accesses on a
// zero-wait-state bus, plus wait-state, timeout and reset sequences.
module tb_lsu_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, is_store;
   logic [2:0]  rwmm;
   logic [31:0] addr, wdata;
   logic        busy, done, misaligned, bus_err;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] m_rdata  = '0;

   lsu_controller #(.TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
      .rwmm(rwmm), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
      .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [2:0]  mode;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] bus;
      logic        flt;
      logic [3:0]  be;
      logic [31:0] ewd;
      logic [31:0] erd;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic st, input logic [2:0] mode, input logic [31:0] a, input logic [31:0] wd);
      start = 1'b1; is_store = st; rwmm = mode; addr = a; wdata = wd;
      step();
      start = 1'b0; is_store = 1'b0; rwmm = 3'b000; addr = '0; wdata = '0;
   endtask

   task automatic run_txn(input vec_t v);
      issue(v.st, v.mode, v.a, v.wd);
      if (v.flt) begin
         chk("flt_done", done, 1);
         chk("flt_mis", misaligned, 1);
         chk("flt_berr", bus_err, 0);
         chk("flt_req", mem_req, 0);
         step();
         chk("flt_idle_busy", busy, 0);
         chk("flt_idle_done", done, 0);
         chk("flt_idle_req", mem_req, 0);
      end else begin
         chk("req", mem_req, 1);
         chk("we", mem_we, v.st);
         chk("addr", mem_addr, {v.a[31:2], 2'b00});
         chk("be", mem_be, v.be);
         if (v.st) chk("wdata", mem_wdata, v.ewd);
         mem_gnt = 1'b1;
         step();
         mem_gnt = 1'b0;
         chk("req_drop", mem_req, 0);
         if (v.st) begin
            chk("st_done", done, 1);
            chk("st_flags", {misaligned, bus_err}, 0);
            chk("st_rdata_kept", rdata, m_rdata);
         end else begin
            chk("ld_wait_done", done, 0);
            chk("ld_wait_busy", busy, 1);
            mem_rvalid = 1'b1; mem_rdata = v.bus;
            step();
            mem_rvalid = 1'b0; mem_rdata = '0;
            chk("ld_done", done, 1);
            chk("ld_flags", {misaligned, bus_err}, 0);
            chk("ld_rdata", rdata, v.erd);
            m_rdata = v.erd;
         end
         step();
         chk("post_done", done, 0);
      end
   endtask

   initial begin
      logic [31:0] s_addr, s_wd;
      logic [3:0]  s_be;
      int unsigned n;

      vecs[0]  = '{1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80};
      vecs[1]  = '{1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF1234, 1'b0, 4'b1000, 32'h0, 32'h00000080};
      vecs[2]  = '{1'b1, 3'b001, 32'h2002, 32'h0000BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
      vecs[3]  = '{1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
      vecs[4]  = '{1'b0, 3'b011, 32'h3000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
      vecs[5]  = '{1'b1, 3'b100, 32'h3000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
      vecs[6]  = '{1'b1, 3'b000, 32'h0011, 32'h123456A5, 32'h0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
      vecs[7]  = '{1'b0, 3'b001, 32'h0002, 32'h0, 32'h80010000, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001};
      vecs[8]  = '{1'b0, 3'b010, 32'h0040, 32'h0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF};
      vecs[9]  = '{1'b1, 3'b010, 32'h0044, 32'hCAFEF00D, 32'h0, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
      vecs[10] = '{1'b0, 3'b101, 32'h0005, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
      vecs[11] = '{1'b1, 3'b001, 32'h0003, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
      vecs[12] = '{1'b0, 3'b000, 32'h0001, 32'h0, 32'h00007F00, 1'b0, 4'b0010, 32'h0, 32'h0000007F};

      rst_n = 1'b0; start = 1'b0; is_store = 1'b0; rwmm = '0; addr = '0; wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      step(); step();
      chk("rst_outs", {busy, done, misaligned, bus_err, mem_req, mem_we}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_rdata", rdata, 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 13; i++) run_txn(vecs[i]);

      // Wait states: LHU at 0x2, grant after 3 stalled REQ cycles, rvalid 2 cycles later.
      // A start pulse during the access must be ignored.
      issue(1'b0, 3'b101, 32'h0000_0002, 32'h0);
      s_addr = mem_addr; s_be = mem_be; s_wd = mem_wdata;
      chk("ws_addr", s_addr, 32'h0);
      chk("ws_be", s_be, 4'b1100);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin start = 1'b1; is_store = 1'b1; rwmm = 3'b010; addr = 32'h500; end
         step();
         start = 1'b0; is_store = 1'b0; rwmm = '0; addr = '0;
         chk("ws_req_hold", mem_req, 1);
         chk("ws_stable", {mem_addr, mem_be, mem_wdata, mem_we}, {s_addr, s_be, s_wd, 1'b0});
         chk("ws_busy", busy, 1);
      end
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
      chk("ws_wait_req", mem_req, 0);
      step();
      chk("ws_wait_busy", {busy, done}, 2'b10);
      mem_rvalid = 1'b1; mem_rdata = 32'hABCD0000; step(); mem_rvalid = 1'b0; mem_rdata = '0;
      chk("ws_done", {done, misaligned, bus_err, busy}, 4'b1000);
      chk("ws_rdata", rdata, 32'h0000ABCD);
      m_rdata = 32'h0000ABCD;
      step();
      chk("ws_no_queue", {busy, mem_req, done}, 0);

      // Timeout: no grant; mem_req stays up for 8 cycles then bus_err.
      issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
      n = 0;
      while (mem_req && n < 20) begin n++; step(); end
      chk("to_cycles", n, 8);
      chk("to_status", {done, bus_err, misaligned, busy}, 4'b1100);
      chk("to_rdata", rdata, m_rdata);
      mem_rvalid = 1'b1; mem_rdata = 32'h11111111; mem_gnt = 1'b1;
      step();
      mem_rvalid = 1'b0; mem_rdata = '0; mem_gnt = 1'b0;
      chk("to_late_ignored", {done, busy, bus_err}, 0);
      chk("to_late_rdata", rdata, m_rdata);
      run_txn(vecs[8]);

      // Grant on the final budgeted cycle beats the timeout.
      issue(1'b1, 3'b010, 32'h0000_0200, 32'h5A5A5A5A);
      for (int i = 0; i < 7; i++) step();
      chk("edge_req", mem_req, 1);
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
      chk("edge_done", {done, bus_err, misaligned}, 3'b100);

      // Reset during WAIT, then a stray rvalid after release.
      step();
      issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
      chk("rw_in_wait", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_async_outs", {busy, done, misaligned, bus_err, mem_req, mem_we}, 0);
      chk("rw_async_bus", {mem_addr, mem_be, mem_wdata}, 0);
      chk("rw_async_rdata", rdata, 0);
      step();
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
      step();
      mem_rvalid = 1'b0; mem_rdata = '0;
      step();
      chk("rw_after", {busy, done, mem_req}, 0);
      chk("rw_after_rdata", rdata, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
Multi-cycle load/store sequencer between the core datapath and the data-memory bus. The core issues a memory instruction using the decoded signals: store flag (wem), access mode (rwmm = funct3), effective address and store data. The block runs a request/grant/response handshake on the memory port, with byte lanes and data aligned to the access width. It returns sign- or zero-extended load data, or an error status for misaligned, illegal-mode or timed-out accesses.

Parameters:
TIMEOUT, 255, cycles allowed in REQ+WAIT before the access aborts with bus_err (1..65535)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  issue request; sampled only in IDLE
is_store  in  1  1 = store (decoder wem), 0 = load
rwmm  in  3  access mode: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  effective byte address
wdata  in  32  store data (rs2)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
rdata  out  32  extended load data; valid with done, held until next done
misaligned  out  1  valid with done: alignment or illegal-mode fault
bus_err  out  1  valid with done: timeout fault
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data word

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, misaligned, bus_err, mem_req, mem_we = 0. mem_addr, mem_be, mem_wdata, rdata = 0. Timeout counter = 0.
- States: IDLE, REQ, WAIT, FAULT.
- IDLE with start=1:
  - Latch is_store, rwmm, addr[1:0], wdata.
  - Legality check:
    - Illegal mode: load rwmm in {011,110,111}; store rwmm > 010.
    - Misaligned: H/HU/SH with addr[0]=1; W with addr[1:0]!=0.
  - Illegal or misaligned -> FAULT.
  - Otherwise -> REQ, with mem_req/mem_we/mem_addr/mem_be/mem_wdata registered so they are valid from the first REQ cycle.
- start while busy: ignored, no queuing.
- FAULT: done=1, misaligned=1 for one cycle -> IDLE. No bus activity.
- mem_be:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- REQ:
  - mem_req and all mem_* outputs held stable until mem_gnt.
  - On gnt, store: drop mem_req, pulse done next cycle, -> IDLE.
  - On gnt, load: drop mem_req, -> WAIT.
- WAIT:
  - On mem_rvalid, register rdata and pulse done next cycle, -> IDLE.
  - Extraction: shift mem_rdata right by 8*addr[1:0], then:
    - B: sign-extend bit 7
    - BU: zero-extend bits [7:0]
    - H: sign-extend bit 15
    - HU: zero-extend bits [15:0]
    - W: unchanged
- Latency with zero wait states:
  - Store: start at T, req at T+1, gnt at T+1, done at T+2.
  - Load: start at T, req/gnt at T+1, rvalid at T+2, done at T+3.
- Timeout:
  - Counter clears on leaving IDLE and increments each cycle in REQ/WAIT.
  - At count == TIMEOUT-1 with no gnt/rvalid: drop mem_req, pulse done with bus_err=1, -> IDLE.
  - rdata unchanged on timeout.
  - gnt/rvalid arriving on that same cycle wins over timeout.
- mem_rvalid in IDLE/REQ and mem_gnt outside REQ: ignored. Covers late responses after timeout or reset.
- misaligned and bus_err are 0 on normal completion. Both are meaningful only while done=1 and are otherwise driven 0.

Test Plan:
- Load LB, addr=0x1003, gnt immediate, mem_rdata=0x80FF1234 at T+2 -> mem_addr=0x1000, mem_be=1000, done at T+3, rdata=0xFFFFFF80. Repeat with LBU -> rdata=0x00000080.
- Store SH, addr=0x2002, wdata=0x0000BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, done at T+2, no rdata change.
- Fault cases:
  - LW addr=0x3001 -> done+misaligned at T+1, mem_req never asserted.
  - Load rwmm=011 -> same response.
  - Store rwmm=100 -> same response.
- Wait states: gnt delayed 3 cycles, rvalid 2 cycles after gnt -> mem_* stable throughout REQ; LHU addr=0x0002, mem_rdata=0xABCD0000 -> rdata=0x0000ABCD; busy high until done.
- TIMEOUT=8, gnt never asserted -> done+bus_err on 8th cycle after entering REQ; later rvalid ignored; next start accepted normally.
- rst_n low while in WAIT, then rvalid after release -> all outputs 0 immediately, no done pulse, state IDLE.
